// File: rtl/iltype_wb_checker.sv
// Shadow-executes accepted I-type ALU / byte-load instructions and checks in-order writebacks against them.
// Expected value formed combinationally at accept; compare results registered (1 cycle); never stalls the core, drops on full.
module iltype_wb_checker #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  input  logic             rf_init_we,
  input  logic [4:0]       rf_init_idx,
  input  logic [31:0]      rf_init_data,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [31:0]      retired_count,
  output logic [31:0]      err_expected,
  output logic [31:0]      err_observed,
  output logic [4:0]       err_rd,
  output logic             fifo_overflow,
  output logic             unexpected_wb,
  output logic             illegal_seen
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] dat;
  } exp_t;

  logic [31:0] shadow_rf [32];

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rs1, rd, shamt;
  logic [31:0] imm, rs1_val, exp_dat;
  logic [3:0]  ld_word;
  logic        ld_carry;
  logic [7:0]  ld_byte;
  logic        legal;

  assign opcode  = instr[6:0];
  assign f3      = instr[14:12];
  assign rs1     = instr[19:15];
  assign rd      = instr[11:7];
  assign shamt   = instr[24:20];
  assign imm     = {{20{instr[31]}}, instr[31:20]};
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : shadow_rf[rs1];

  // Only address bits [5:2] select a dmem word, so just that slice of rs1+imm is formed.
  assign ld_carry = ({1'b0, rs1_val[1:0]} + {1'b0, imm[1:0]}) >= 3'd4;
  assign ld_word  = rs1_val[5:2] + imm[5:2] + {3'b000, ld_carry};
  assign ld_byte  = {ld_word, ld_word};

  always_comb begin
    legal   = 1'b0;
    exp_dat = 32'd0;
    case (opcode)
      7'b0010011: begin
        legal = 1'b1;
        case (f3)
          3'd0: exp_dat = rs1_val + imm;
          3'd1: exp_dat = rs1_val << shamt;
          3'd2: exp_dat = {31'd0, $signed(rs1_val) < $signed(imm)};
          3'd3: exp_dat = {31'd0, rs1_val < imm};
          3'd4: exp_dat = rs1_val ^ imm;
          3'd5: exp_dat = instr[30] ? 32'($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
          3'd6: exp_dat = rs1_val | imm;
          3'd7: exp_dat = rs1_val & imm;
          default: exp_dat = 32'd0;
        endcase
      end
      7'b0000011: begin
        case (f3)
          3'd0: begin
            legal   = 1'b1;
            exp_dat = {{24{ld_byte[7]}}, ld_byte};
          end
          3'd4: begin
            legal   = 1'b1;
            exp_dat = {24'd0, ld_byte};
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  exp_t          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          fifo_empty, fifo_full;
  logic          push_req, push, wb_act, pop, wb_match;
  exp_t          head, observed;

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == DEPTH_L);
  assign push_req   = instr_valid && legal && (rd != 5'd0);
  assign wb_act     = wb_valid && (wb_rd != 5'd0);
  assign pop        = wb_act && !fifo_empty;
  assign push       = push_req && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr];
  assign observed   = '{rd: wb_rd, dat: wb_data};
  assign wb_match   = (head == observed);

  // Mirrors the core regfile, so no reset; a same-cycle accept overrides a preload.
  always_ff @(posedge clk) begin
    if (rf_init_we && (rf_init_idx != 5'd0))
      shadow_rf[rf_init_idx] <= rf_init_data;
    if (push_req)
      shadow_rf[rd] <= exp_dat;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= '{rd: rd, dat: exp_dat};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      mismatch       <= 1'b0;
      mismatch_count <= '0;
      retired_count  <= 32'd0;
      err_expected   <= 32'd0;
      err_observed   <= 32'd0;
      err_rd         <= 5'd0;
      fifo_overflow  <= 1'b0;
      unexpected_wb  <= 1'b0;
      illegal_seen   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (push_req && fifo_full && !pop)
        fifo_overflow <= 1'b1;
      if (instr_valid && !legal)
        illegal_seen <= 1'b1;
      if (wb_act && fifo_empty)
        unexpected_wb <= 1'b1;
      if (pop) begin
        if (wb_match) begin
          retired_count <= retired_count + 32'd1;
        end else begin
          mismatch <= 1'b1;
          if (mismatch_count != '1)
            mismatch_count <= mismatch_count + 1'b1;
          if (!mismatch) begin
            err_expected <= head.dat;
            err_observed <= wb_data;
            err_rd       <= head.rd;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_iltype_wb_checker.sv
// Directed bench for iltype_wb_checker: queue-based reference model checked every cycle, plus literal pins.
module tb_iltype_wb_checker;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_init_we;
  logic [4:0]  rf_init_idx;
  logic [31:0] rf_init_data;
  logic        mismatch;
  logic [15:0] mismatch_count;
  logic [31:0] retired_count;
  logic [31:0] err_expected;
  logic [31:0] err_observed;
  logic [4:0]  err_rd;
  logic        fifo_overflow;
  logic        unexpected_wb;
  logic        illegal_seen;

  always #5 clk = ~clk;

  iltype_wb_checker #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr(instr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_init_we(rf_init_we), .rf_init_idx(rf_init_idx), .rf_init_data(rf_init_data),
    .mismatch(mismatch), .mismatch_count(mismatch_count), .retired_count(retired_count),
    .err_expected(err_expected), .err_observed(err_observed), .err_rd(err_rd),
    .fifo_overflow(fifo_overflow), .unexpected_wb(unexpected_wb), .illegal_seen(illegal_seen)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_rf [32];
  logic [4:0]  mq_rd [$];
  logic [31:0] mq_dat [$];
  bit          m_mis, m_ovf, m_unexp, m_ill;
  int          m_miscnt;
  logic [31:0] m_ret, m_eexp, m_eobs;
  logic [4:0]  m_erd;

  initial for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;

  function automatic void ref_exec(input logic [31:0] ins, output bit ok, output logic [31:0] val);
    logic signed [11:0] i12;
    int          simm, b, w;
    logic [31:0] a, uimm, addr;
    i12  = ins[31:20];
    simm = i12;
    uimm = simm;
    a    = m_rf[ins[19:15]];
    ok   = 1'b1;
    val  = 32'd0;
    if (ins[6:0] == 7'h13) begin
      case (ins[14:12])
        3'd0: val = a + uimm;
        3'd1: val = a << ins[24:20];
        3'd2: val = (int'(a) < simm) ? 32'd1 : 32'd0;
        3'd3: val = (a < uimm) ? 32'd1 : 32'd0;
        3'd4: val = a ^ uimm;
        3'd5: begin
          if (ins[30]) val = int'(a) >>> ins[24:20];
          else         val = a >> ins[24:20];
        end
        3'd6: val = a | uimm;
        default: val = a & uimm;
      endcase
    end else if (ins[6:0] == 7'h03 && (ins[14:12] == 3'd0 || ins[14:12] == 3'd4)) begin
      addr = a + uimm;
      w    = int'((addr / 4) % 16);
      b    = w * 17;
      if (ins[14:12] == 3'd0 && b >= 128) val = b - 256;
      else                                val = b;
    end else begin
      ok = 1'b0;
    end
  endfunction

  always @(posedge clk) begin : model
    bit          ok;
    logic [31:0] v, hd;
    logic [4:0]  hr;
    ref_exec(instr, ok, v);
    if (reset) begin
      mq_rd.delete(); mq_dat.delete();
      m_mis = 0; m_ovf = 0; m_unexp = 0; m_ill = 0; m_miscnt = 0;
      m_ret = 0; m_eexp = 0; m_eobs = 0; m_erd = 0;
    end else begin
      if (wb_valid && wb_rd != 5'd0) begin
        if (mq_rd.size() == 0) m_unexp = 1;
        else begin
          hr = mq_rd.pop_front();
          hd = mq_dat.pop_front();
          if (hr == wb_rd && hd == wb_data) m_ret = m_ret + 1;
          else begin
            if (!m_mis) begin m_eexp = hd; m_eobs = wb_data; m_erd = hr; end
            m_mis = 1;
            if (m_miscnt < 65535) m_miscnt++;
          end
        end
      end
      if (instr_valid) begin
        if (!ok) m_ill = 1;
        else if (instr[11:7] != 5'd0) begin
          if (mq_rd.size() < DEPTH) begin mq_rd.push_back(instr[11:7]); mq_dat.push_back(v); end
          else m_ovf = 1;
        end
      end
    end
    if (rf_init_we && rf_init_idx != 5'd0) m_rf[rf_init_idx] = rf_init_data;
    if (instr_valid && ok && instr[11:7] != 5'd0) m_rf[instr[11:7]] = v;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mismatch",       mismatch,       m_mis);
      chk("mismatch_count", mismatch_count, 32'(m_miscnt));
      chk("retired_count",  retired_count,  m_ret);
      chk("err_expected",   err_expected,   m_eexp);
      chk("err_observed",   err_observed,   m_eobs);
      chk("err_rd",         err_rd,         m_erd);
      chk("fifo_overflow",  fifo_overflow,  m_ovf);
      chk("unexpected_wb",  unexpected_wb,  m_unexp);
      chk("illegal_seen",   illegal_seen,   m_ill);
    end
  end

  task automatic step(input bit iv, input logic [31:0] ins, input bit wv, input logic [4:0] wr,
                      input logic [31:0] wd, input bit pv = 0, input logic [4:0] pi = 0,
                      input logic [31:0] pd = 0, input bit rst = 0);
    reset = rst; instr_valid = iv; instr = ins;
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    rf_init_we = pv; rf_init_idx = pi; rf_init_data = pd;
    @(negedge clk);
    reset = 0; instr_valid = 0; wb_valid = 0; rf_init_we = 0;
  endtask

  task automatic acc(input logic [31:0] ins);
    step(1, ins, 0, 0, 0);
  endtask
  task automatic wbk(input logic [4:0] r, input logic [31:0] d);
    step(0, 0, 1, r, d);
  endtask
  task automatic pre(input logic [4:0] r, input logic [31:0] d);
    step(0, 0, 0, 0, 0, 1, r, d);
  endtask
  task automatic rst_cycle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  function automatic logic [31:0] addi_k(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  logic [31:0] tbl_ins [8] = '{32'h0000A113, 32'hFFF0B113, 32'hFFF0C113, 32'h0100E113,
                               32'h00F0F113, 32'h00109113, 32'hFFE08113, 32'hFFC0C103};
  logic [31:0] tbl_exp [8] = '{32'h00000001, 32'h00000001, 32'h7FFFFFFE, 32'h80000011,
                               32'h00000001, 32'h00000002, 32'h7FFFFFFF, 32'h000000FF};

  initial begin
    reset = 1; instr_valid = 0; instr = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
    rf_init_we = 0; rf_init_idx = 0; rf_init_data = 0;
    @(negedge clk);
    for (int i = 1; i < 32; i++) step(0, 0, 0, 0, 0, 1, 5'(i), 32'd0, 1);
    chk_en = 1;
    chk("reset_retired", retired_count, 32'd0);
    chk("reset_mismatch", mismatch, 1'b0);

    acc(32'h00500093);
    wbk(1, 32'd5);
    chk("addi_retired", retired_count, 32'd1);
    chk("addi_model", m_ret, 32'd1);

    pre(2, 32'h0000000C);
    acc(32'h00010183);
    wbk(3, 32'h00000033);
    pre(2, 32'h00000024);
    acc(32'h00010183);
    wbk(3, 32'hFFFFFF99);
    acc(32'h00014303);
    wbk(6, 32'h00000099);
    chk("load_retired", retired_count, 32'd4);
    chk("load_mismatch", mismatch, 1'b0);

    acc(32'hFFF00093);
    acc(32'h4040D213);
    acc(32'h0040D293);
    wbk(1, 32'hFFFFFFFF);
    wbk(4, 32'hFFFFFFFF);
    wbk(5, 32'h0FFFFFFF);
    chk("shift_retired", retired_count, 32'd7);

    pre(1, 32'h80000001);
    for (int i = 0; i < 8; i++) begin
      acc(tbl_ins[i]);
      wbk(2, tbl_exp[i]);
    end
    chk("table_retired", retired_count, 32'd15);
    chk("table_model", m_ret, 32'd15);

    step(1, 32'h00700293, 0, 0, 0, 1, 5'd5, 32'h00001234);
    acc(32'h00028313);
    wbk(5, 32'd7);
    wbk(6, 32'd7);
    chk("preload_vs_accept", retired_count, 32'd17);

    acc(32'h00500093);
    wbk(1, 32'd6);
    chk("mis_flag", mismatch, 1'b1);
    chk("mis_count1", mismatch_count, 32'd1);
    chk("err_expected", err_expected, 32'd5);
    chk("err_observed", err_observed, 32'd6);
    chk("err_rd", err_rd, 32'd1);
    acc(32'h00500093);
    wbk(1, 32'd7);
    chk("mis_count2", mismatch_count, 32'd2);
    chk("err_observed_kept", err_observed, 32'd6);
    wbk(0, 32'h123);
    chk("wb_x0_ignored", unexpected_wb, 1'b0);

    rst_cycle();
    chk("rst_retired", retired_count, 32'd0);
    for (int k = 1; k <= 9; k++) acc(addi_k(k));
    chk("overflow_set", fifo_overflow, 1'b1);
    for (int k = 1; k <= 8; k++) wbk(5'(k), 32'(k));
    chk("drain_retired", retired_count, 32'd8);
    chk("drain_unexp", unexpected_wb, 1'b0);

    rst_cycle();
    for (int k = 1; k <= 8; k++) acc(addi_k(k));
    step(1, addi_k(9), 1, 5'd1, 32'd1);
    chk("full_push_pop_no_ovf", fifo_overflow, 1'b0);
    for (int k = 2; k <= 9; k++) wbk(5'(k), 32'(k));
    chk("full_drain_retired", retired_count, 32'd9);

    for (int k = 1; k <= 3; k++) acc(addi_k(k));
    rst_cycle();
    wbk(1, 32'd1);
    chk("post_rst_unexp", unexpected_wb, 1'b1);
    chk("post_rst_retired", retired_count, 32'd0);

    rst_cycle();
    step(1, addi_k(1), 1, 5'd1, 32'd1);
    chk("empty_push_pop_unexp", unexpected_wb, 1'b1);
    wbk(1, 32'd1);
    chk("empty_push_pop_retired", retired_count, 32'd1);

    rst_cycle();
    acc(32'h00001183);
    chk("illegal_lh", illegal_seen, 1'b1);
    rst_cycle();
    acc(32'h00000033);
    chk("illegal_op33", illegal_seen, 1'b1);
    acc(32'h00000013);
    wbk(1, 32'd0);
    chk("nop_not_enqueued", unexpected_wb, 1'b1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
